omi_link_seq: RTL and testbench

Link bring-up sequencer for one OMI endpoint (host or device side) in the omi_host_fire design. It steps the Xilinx PHY reset handshake, holds and releases the DLx, and gates the DLx training-state-machine transitions (tsm_state2_to_3, tsm_state4_to_5, tsm_state6_to_1). Today those transitions are tied high; this block replaces the ties. It supervises training with a timeout and bounded retries, and exposes status for CSR readback.

---
 rtl/omi_link_seq_pkg.sv | 19 +
 rtl/omi_link_seq_timer.sv | 26 ++
 rtl/omi_link_seq.sv | 171 +++++++++++++++++
 tb/tb_omi_link_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/omi_link_seq_pkg.sv
// Shared types for the OMI link bring-up sequencer: state encoding and field widths.
package omi_link_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 4;
    localparam int unsigned RETRY_W     = 2;

    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_PHY_RST  = 4'd1,
        ST_PHY_WAIT = 4'd2,
        ST_DLX_RST  = 4'd3,
        ST_TRAIN_23 = 4'd4,
        ST_TRAIN_45 = 4'd5,
        ST_UP       = 4'd6,
        ST_RETRAIN  = 4'd7,
        ST_FAIL     = 4'd8
    } seq_state_e;

endpackage

// File: rtl/omi_link_seq_timer.sv
// Loadable down-counter shared by all timed sequencer states; zero_c marks the last cycle.
module omi_link_seq_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero_c = (cnt == '0);

endmodule

// File: rtl/omi_link_seq.sv
// OMI link bring-up sequencer: PHY reset handshake, DLx reset and training-gate control with retries.
// Define OMI_LINK_SEQ_AUTO_RETRAIN_EN to retrain on link loss in UP instead of failing.
module omi_link_seq
    import omi_link_seq_pkg::*;
#(
    parameter int unsigned PHY_RST_CYCLES = 16,
    parameter int unsigned DLX_RST_CYCLES = 8,
    parameter int unsigned STEP_CYCLES    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic                   cfg_retrain,
    input  logic                   gtwiz_reset_tx_done_in,
    input  logic                   gtwiz_reset_rx_done_in,
    input  logic                   gtwiz_buffbypass_tx_done_in,
    input  logic                   gtwiz_buffbypass_rx_done_in,
    input  logic                   gtwiz_userclk_tx_active_in,
    input  logic                   gtwiz_userclk_rx_active_in,
    input  logic                   link_up,
    output logic                   gtwiz_reset_all_out,
    output logic                   dlx_reset,
    output logic                   tsm_state2_to_3,
    output logic                   tsm_state4_to_5,
    output logic                   tsm_state6_to_1,
    output logic [SEQ_STATE_W-1:0] seq_state,
    output logic [RETRY_W-1:0]     retry_cnt,
    output logic                   timeout_err,
    output logic                   link_ready
);

    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    seq_state_e         state, state_d;
    logic               timer_zero_c;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_load_val;
    logic               phy_ready;
    logic               last_retry;
    logic               start_evt;
    logic               retry_evt;
    logic               link_fail_evt;

    assign phy_ready  = gtwiz_reset_tx_done_in & gtwiz_reset_rx_done_in &
                        gtwiz_buffbypass_tx_done_in & gtwiz_buffbypass_rx_done_in &
                        gtwiz_userclk_tx_active_in & gtwiz_userclk_rx_active_in;
    assign last_retry = (retry_cnt == RETRY_W'(MAX_RETRIES - 1));

    // Next-state logic; success is tested before timeout so a tie resolves as success.
    always_comb begin
        state_d       = state;
        start_evt     = 1'b0;
        retry_evt     = 1'b0;
        link_fail_evt = 1'b0;
        case (state)
            ST_IDLE, ST_FAIL: begin
                if (cfg_start) begin
                    state_d   = ST_PHY_RST;
                    start_evt = 1'b1;
                end
            end
            ST_PHY_RST:  if (timer_zero_c) state_d = ST_PHY_WAIT;
            ST_PHY_WAIT: begin
                if (phy_ready) begin
                    state_d = ST_DLX_RST;
                end else if (timer_zero_c) begin
                    retry_evt = 1'b1;
                    state_d   = last_retry ? ST_FAIL : ST_PHY_RST;
                end
            end
            ST_DLX_RST:  if (timer_zero_c) state_d = ST_TRAIN_23;
            ST_TRAIN_23: if (timer_zero_c) state_d = ST_TRAIN_45;
            ST_TRAIN_45: begin
                if (link_up) begin
                    state_d = ST_UP;
                end else if (timer_zero_c) begin
                    retry_evt = 1'b1;
                    state_d   = last_retry ? ST_FAIL : ST_PHY_RST;
                end
            end
            ST_UP: begin
`ifdef OMI_LINK_SEQ_AUTO_RETRAIN_EN
                if (cfg_retrain || !link_up) state_d = ST_RETRAIN;
`else
                if (!link_up) begin
                    state_d       = ST_FAIL;
                    link_fail_evt = 1'b1;
                end else if (cfg_retrain) begin
                    state_d = ST_RETRAIN;
                end
`endif
            end
            ST_RETRAIN:  state_d = ST_TRAIN_23;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Timer reloads on every state change with the dwell of the state being entered.
    always_comb begin
        timer_load     = (state_d != state);
        timer_load_val = '0;
        case (state_d)
            ST_PHY_RST:               timer_load_val = TIMER_W'(PHY_RST_CYCLES - 1);
            ST_PHY_WAIT, ST_TRAIN_45: timer_load_val = TIMER_W'(TIMEOUT_CYCLES - 1);
            ST_DLX_RST:               timer_load_val = TIMER_W'(DLX_RST_CYCLES - 1);
            ST_TRAIN_23:              timer_load_val = TIMER_W'(STEP_CYCLES - 1);
            default:                  timer_load_val = '0;
        endcase
    end

    omi_link_seq_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero_c   (timer_zero_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    assign seq_state = state;

    // Outputs decoded from the next state so they move together with seq_state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gtwiz_reset_all_out <= 1'b0;
            dlx_reset           <= 1'b1;
            tsm_state2_to_3     <= 1'b0;
            tsm_state4_to_5     <= 1'b0;
            tsm_state6_to_1     <= 1'b0;
            link_ready          <= 1'b0;
        end else begin
            gtwiz_reset_all_out <= (state_d == ST_PHY_RST);
            dlx_reset           <= (state_d == ST_IDLE) || (state_d == ST_PHY_RST) ||
                                   (state_d == ST_PHY_WAIT) || (state_d == ST_DLX_RST) ||
                                   (state_d == ST_FAIL);
            tsm_state2_to_3     <= (state_d == ST_TRAIN_23) || (state_d == ST_TRAIN_45) ||
                                   (state_d == ST_UP);
            tsm_state4_to_5     <= (state_d == ST_TRAIN_45) || (state_d == ST_UP);
            tsm_state6_to_1     <= (state_d == ST_RETRAIN);
            link_ready          <= (state_d == ST_UP);
        end
    end

    // Error status: cleared by a start, bumped on every timeout, saturating retry count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retry_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (start_evt) begin
            retry_cnt   <= '0;
            timeout_err <= 1'b0;
        end else if (retry_evt) begin
            timeout_err <= 1'b1;
            if (retry_cnt != '1) retry_cnt <= retry_cnt + RETRY_W'(1);
        end else if (link_fail_evt) begin
            timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_omi_link_seq.sv
// Directed self-checking bench for omi_link_seq with a shortened training timeout.
module tb_omi_link_seq;

    localparam int unsigned PHY_RST  = 16;
    localparam int unsigned DLX_RST  = 8;
    localparam int unsigned STEP     = 32;
    localparam int unsigned TIMEOUT  = 64;
    localparam int unsigned RETRIES  = 3;
    localparam int unsigned T45_LOW  = 10;

    logic       clk;
    logic       rst;
    logic       cfg_start;
    logic       cfg_retrain;
    logic       gt_tx_done, gt_rx_done, bb_tx_done, bb_rx_done, uc_tx_act, uc_rx_act;
    logic       link_up;
    logic       gtwiz_reset_all_out;
    logic       dlx_reset;
    logic       tsm_state2_to_3, tsm_state4_to_5, tsm_state6_to_1;
    logic [3:0] seq_state;
    logic [1:0] retry_cnt;
    logic       timeout_err;
    logic       link_ready;

    int n_tests = 0;
    int n_fail  = 0;

    omi_link_seq #(
        .PHY_RST_CYCLES (PHY_RST),
        .DLX_RST_CYCLES (DLX_RST),
        .STEP_CYCLES    (STEP),
        .TIMEOUT_CYCLES (TIMEOUT),
        .MAX_RETRIES    (RETRIES)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .cfg_start                   (cfg_start),
        .cfg_retrain                 (cfg_retrain),
        .gtwiz_reset_tx_done_in      (gt_tx_done),
        .gtwiz_reset_rx_done_in      (gt_rx_done),
        .gtwiz_buffbypass_tx_done_in (bb_tx_done),
        .gtwiz_buffbypass_rx_done_in (bb_rx_done),
        .gtwiz_userclk_tx_active_in  (uc_tx_act),
        .gtwiz_userclk_rx_active_in  (uc_rx_act),
        .link_up                     (link_up),
        .gtwiz_reset_all_out         (gtwiz_reset_all_out),
        .dlx_reset                   (dlx_reset),
        .tsm_state2_to_3             (tsm_state2_to_3),
        .tsm_state4_to_5             (tsm_state4_to_5),
        .tsm_state6_to_1             (tsm_state6_to_1),
        .seq_state                   (seq_state),
        .retry_cnt                   (retry_cnt),
        .timeout_err                 (timeout_err),
        .link_ready                  (link_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget);
        int i = 0;
        while (seq_state != s && i < budget) begin
            tick();
            i++;
        end
    endtask

    function automatic logic [2:0] gates();
        return {tsm_state6_to_1, tsm_state4_to_5, tsm_state2_to_3};
    endfunction

    initial begin
        int n;
        int t45;
        int len;
        int pw;
        logic seen61;

        rst = 1'b0; cfg_start = 1'b0; cfg_retrain = 1'b0; link_up = 1'b0;
        gt_tx_done = 1'b1; gt_rx_done = 1'b1; bb_tx_done = 1'b1;
        bb_rx_done = 1'b1; uc_tx_act = 1'b1; uc_rx_act = 1'b1;

        // Reset values
        repeat (2) tick();
        check("rst_state", seq_state, 4'd0);
        check("rst_dlx", dlx_reset, 1'b1);
        check("rst_gao", gtwiz_reset_all_out, 1'b0);
        check("rst_gates", gates(), 3'b000);
        check("rst_ready", link_ready, 1'b0);
        check("rst_retry", retry_cnt, 2'd0);
        check("rst_terr", timeout_err, 1'b0);
        rst = 1'b1;
        tick();
        check("idle_hold", seq_state, 4'd0);

        // Bring-up with link_up low for the first T45_LOW cycles of TRAIN_45
        pulse_start();
        n = 1;
        check("start_state", seq_state, 4'd1);
        check("start_gao", gtwiz_reset_all_out, 1'b1);
        seen61 = tsm_state6_to_1;
        t45 = 0;
        while (!link_ready && n < 300) begin
            if (seq_state == 4'd5) begin
                t45++;
                if (t45 == T45_LOW + 1) link_up = 1'b1;
            end
            tick();
            n++;
            seen61 |= tsm_state6_to_1;
        end
        check("up_latency", n, 1 + PHY_RST + 1 + DLX_RST + STEP + 1 + T45_LOW);
        check("up_state", seq_state, 4'd6);
        check("up_gates", gates(), 3'b011);
        check("up_dlx", dlx_reset, 1'b0);
        check("no_6to1", seen61, 1'b0);

        // cfg_start ignored in UP, then a single-cycle retrain
        pulse_start();
        check("start_ignored", seq_state, 4'd6);
        cfg_retrain = 1'b1;
        tick();
        cfg_retrain = 1'b0;
        n = 1;
        check("retrain_state", seq_state, 4'd7);
        check("retrain_gates", gates(), 3'b100);
        check("retrain_ready", link_ready, 1'b0);
        tick();
        n++;
        check("retrain_t23", seq_state, 4'd4);
        check("retrain_t23_gates", gates(), 3'b001);
        while (!link_ready && n < 100) begin
            tick();
            n++;
        end
        check("retrain_latency", n, 1 + 1 + STEP + 1);

        // Link loss in UP
        link_up = 1'b0;
        tick();
`ifdef OMI_LINK_SEQ_AUTO_RETRAIN_EN
        check("drop_state", seq_state, 4'd7);
        check("drop_gates", gates(), 3'b100);
        tick();
        check("drop_t23", seq_state, 4'd4);
        wait_state(4'd5, 100);
`else
        check("drop_state", seq_state, 4'd8);
        check("drop_terr", timeout_err, 1'b1);
        check("drop_dlx", dlx_reset, 1'b1);
        check("drop_gates", gates(), 3'b000);
        check("drop_ready", link_ready, 1'b0);
        pulse_start();
        check("fail_start_terr", timeout_err, 1'b0);
        wait_state(4'd5, 200);
`endif
        check("in_t45", seq_state, 4'd5);

        // Asynchronous reset mid-cycle in TRAIN_45
        #2;
        rst = 1'b0;
        #1;
        check("arst_state", seq_state, 4'd0);
        check("arst_dlx", dlx_reset, 1'b1);
        check("arst_gates", gates(), 3'b000);
        check("arst_gao", gtwiz_reset_all_out, 1'b0);
        tick();
        rst = 1'b1;
        gt_rx_done = 1'b0;
        tick();

        // PHY never ready: three timeouts then FAIL
        pulse_start();
        check("restart_state", seq_state, 4'd1);
        check("restart_retry", retry_cnt, 2'd0);
        check("restart_terr", timeout_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            len = 0;
            while (gtwiz_reset_all_out && len < 100) begin
                len++;
                tick();
            end
            check("phy_rst_len", len, PHY_RST);
            check("retry_before", retry_cnt, k);
            pw = 0;
            while (seq_state == 4'd2 && pw < 200) begin
                pw++;
                tick();
            end
            check("phy_wait_len", pw, TIMEOUT);
            check("retry_after", retry_cnt, k + 1);
            check("terr_after", timeout_err, 1'b1);
            check("after_timeout_state", seq_state, (k < 2) ? 4'd1 : 4'd8);
        end
        check("fail_dlx", dlx_reset, 1'b1);
        check("fail_gates", gates(), 3'b000);
        repeat (3) tick();
        check("fail_hold", seq_state, 4'd8);
        gt_rx_done = 1'b1;
        pulse_start();
        check("fail_exit_state", seq_state, 4'd1);
        check("fail_exit_retry", retry_cnt, 2'd0);
        check("fail_exit_terr", timeout_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
